// File: rtl/bus_cycle_ctrl_pkg.sv
// Shared types and helpers for the 8085 bus-cycle controller.
// Defines the cycle-type and bus-state enums, the S1/S0 status codes and
// read/valid classification helpers used by the controller and its encoder.
package i8085_bus_pkg;

  // External machine-cycle kinds; encodings 6 and 7 are no-ops.
  typedef enum logic [2:0] {
    CYC_OPF = 3'd0,
    CYC_MRD = 3'd1,
    CYC_MWR = 3'd2,
    CYC_IOR = 3'd3,
    CYC_IOW = 3'd4,
    CYC_INA = 3'd5
  } cyc_type_e;

  // Machine-cycle T-states.
  typedef enum logic [2:0] {
    BS_IDLE = 3'd0,
    BS_T1   = 3'd1,
    BS_T2   = 3'd2,
    BS_TW   = 3'd3,
    BS_T3   = 3'd4
  } bus_state_e;

  // S1/S0 status codes.
  localparam logic [1:0] ST_OPF  = 2'b11;
  localparam logic [1:0] ST_RD   = 2'b10;
  localparam logic [1:0] ST_WR   = 2'b01;
  localparam logic [1:0] ST_NONE = 2'b00;

  // Width of the TW counter; covers the full 1..255 wait limit.
  localparam int WAIT_CNT_W = 8;

  // True for cycles that sample the AD bus (opcode fetch, reads, int-ack).
  function automatic logic is_read(cyc_type_e t);
    return (t == CYC_OPF) || (t == CYC_MRD) || (t == CYC_IOR) || (t == CYC_INA);
  endfunction

  // True for encodings that start a real bus cycle.
  function automatic logic is_valid_cyc(logic [2:0] t);
    return t <= 3'd5;
  endfunction

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// Request and external-bus signal bundle for bus_cycle_ctrl.
// slave: the controller's view; master: the requester/bus-model view.
interface bus_cycle_ctrl_if;

  logic        start;
  logic [2:0]  cyc_type;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ready;
  logic [7:0]  ad_in;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic [7:0]  a_hi;
  logic        ale;
  logic        rd_n;
  logic        wr_n;
  logic        inta_n;
  logic        iom_n;
  logic        s1;
  logic        s0;
  logic        req_rdy;
  logic        done;
  logic        bus_err;
  logic [7:0]  rdata;
  logic        rdata_vld;
  logic [7:0]  instr;

  modport slave (
    input  start, cyc_type, addr, wdata, ready, ad_in,
    output ad_out, ad_oe, a_hi, ale, rd_n, wr_n, inta_n, iom_n, s1, s0,
           req_rdy, done, bus_err, rdata, rdata_vld, instr
  );

  modport master (
    output start, cyc_type, addr, wdata, ready, ad_in,
    input  ad_out, ad_oe, a_hi, ale, rd_n, wr_n, inta_n, iom_n, s1, s0,
           req_rdy, done, bus_err, rdata, rdata_vld, instr
  );

endinterface

// File: rtl/bus_cycle_ctrl_status_enc.sv
// bus_status_enc: maps a cycle type to its 8085 status pins and the
// read / interrupt-acknowledge flags that steer the T2 strobes.
module bus_status_enc
  import i8085_bus_pkg::*;
(
  input  logic [2:0] cyc_type_i,
  output logic       iom_n_o,
  output logic       s1_o,
  output logic       s0_o,
  output logic       is_read_o,
  output logic       is_inta_o
);

  cyc_type_e ty;
  assign ty = cyc_type_e'(cyc_type_i);

  // Status table lookup; no-op encodings decode to an all-zero status.
  always_comb begin
    iom_n_o    = 1'b0;
    {s1_o, s0_o} = ST_NONE;
    is_read_o  = 1'b0;
    is_inta_o  = 1'b0;
    if (is_valid_cyc(cyc_type_i)) begin
      is_read_o = is_read(ty);
      case (ty)
        CYC_OPF: {s1_o, s0_o} = ST_OPF;
        CYC_MRD: {s1_o, s0_o} = ST_RD;
        CYC_MWR: {s1_o, s0_o} = ST_WR;
        CYC_IOR: begin
          {s1_o, s0_o} = ST_RD;
          iom_n_o      = 1'b1;
        end
        CYC_IOW: begin
          {s1_o, s0_o} = ST_WR;
          iom_n_o      = 1'b1;
        end
        CYC_INA: begin
          {s1_o, s0_o} = ST_OPF;
          iom_n_o      = 1'b1;
          is_inta_o    = 1'b1;
        end
        default: {s1_o, s0_o} = ST_NONE;
      endcase
    end
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: runs one 8085 external machine cycle (T1/T2/[TW]/T3) per
// accepted request, drives the multiplexed AD bus and strobes, returns read
// data and latches fetched opcodes into instr for the decoder.
// All outputs are registered as a function of the next T-state.
// Optional feature macro BUS_WAIT_STATE_EN: when defined, READY is honoured,
// TW states and the MAX_WAIT timeout (bus_err) exist; when undefined, T2
// always proceeds to T3 and bus_err is constant 0.
module bus_cycle_ctrl
  import i8085_bus_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input logic             phi1,
  input logic             reset,
  bus_cycle_ctrl_if.slave bus
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

  bus_state_e state_q, state_d;
  logic       accept;

  logic [7:0] ad_out_q;
  logic       ad_oe_q;
  logic [7:0] a_hi_q;
  logic       ale_q;
  logic       rd_n_q;
  logic       wr_n_q;
  logic       inta_n_q;
  logic       iom_n_q;
  logic       s1_q;
  logic       s0_q;
  logic       req_rdy_q;
  logic       done_q;
  logic [7:0] rdata_q;
  logic       rdata_vld_q;
  logic [7:0] instr_q;

  // Attributes of the cycle in flight, captured on accept.
  logic       is_read_q;
  logic       is_inta_q;
  logic       is_opf_q;
  logic [7:0] wdata_q;

  logic enc_iom_n, enc_s1, enc_s0, enc_is_read, enc_is_inta;
  logic t3_err;

  bus_status_enc u_status_enc (
    .cyc_type_i (bus.cyc_type),
    .iom_n_o    (enc_iom_n),
    .s1_o       (enc_s1),
    .s0_o       (enc_s0),
    .is_read_o  (enc_is_read),
    .is_inta_o  (enc_is_inta)
  );

`ifdef BUS_WAIT_STATE_EN
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  timeout;
  logic                  bus_err_q;

  assign t3_err      = bus_err_q;
  assign bus.bus_err = bus_err_q;

  // Wait-state counter: 1 in the first TW, +1 per further TW.
  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= (state_d == BS_T3) && timeout;
    end
  end
`else
  logic unused_cfg;

  assign t3_err      = 1'b0;
  assign bus.bus_err = 1'b0;
  assign unused_cfg  = &{1'b0, bus.ready, WAIT_LIMIT};
`endif

  // Next-state logic; requests are only looked at in IDLE and T3.
  always_comb begin
    accept  = bus.start && is_valid_cyc(bus.cyc_type);
    state_d = state_q;
`ifdef BUS_WAIT_STATE_EN
    wait_cnt_d = wait_cnt_q;
    timeout    = 1'b0;
`endif
    case (state_q)
      BS_IDLE: if (accept) state_d = BS_T1;
      BS_T1:   state_d = BS_T2;
      BS_T2: begin
`ifdef BUS_WAIT_STATE_EN
        if (bus.ready) begin
          state_d = BS_T3;
        end else begin
          state_d    = BS_TW;
          wait_cnt_d = WAIT_CNT_W'(1);
        end
`else
        state_d = BS_T3;
`endif
      end
      BS_TW: begin
`ifdef BUS_WAIT_STATE_EN
        if (bus.ready) begin
          state_d = BS_T3;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          state_d = BS_T3;
          timeout = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
`else
        state_d = BS_T3;
`endif
      end
      BS_T3:   state_d = accept ? BS_T1 : BS_IDLE;
      default: state_d = BS_IDLE;
    endcase
  end

  // FSM state and registered bus outputs keyed on the next T-state.
  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      state_q     <= BS_IDLE;
      ad_out_q    <= 8'h00;
      ad_oe_q     <= 1'b0;
      a_hi_q      <= 8'h00;
      ale_q       <= 1'b0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      inta_n_q    <= 1'b1;
      iom_n_q     <= 1'b0;
      {s1_q, s0_q} <= ST_NONE;
      req_rdy_q   <= 1'b1;
      done_q      <= 1'b0;
      rdata_q     <= 8'h00;
      rdata_vld_q <= 1'b0;
      instr_q     <= 8'h00;
      is_read_q   <= 1'b0;
      is_inta_q   <= 1'b0;
      is_opf_q    <= 1'b0;
      wdata_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      done_q      <= 1'b0;
      rdata_vld_q <= 1'b0;

      // Read data is taken on the edge that ends T3, unless the cycle timed out.
      if ((state_q == BS_T3) && is_read_q && !t3_err) begin
        rdata_q     <= bus.ad_in;
        rdata_vld_q <= 1'b1;
        if (is_opf_q) instr_q <= bus.ad_in;
      end

      case (state_d)
        BS_IDLE: begin
          ale_q        <= 1'b0;
          ad_oe_q      <= 1'b0;
          rd_n_q       <= 1'b1;
          wr_n_q       <= 1'b1;
          inta_n_q     <= 1'b1;
          {s1_q, s0_q} <= ST_NONE;
          req_rdy_q    <= 1'b1;
        end
        BS_T1: begin
          ale_q     <= 1'b1;
          ad_oe_q   <= 1'b1;
          ad_out_q  <= bus.addr[7:0];
          a_hi_q    <= bus.addr[15:8];
          rd_n_q    <= 1'b1;
          wr_n_q    <= 1'b1;
          inta_n_q  <= 1'b1;
          iom_n_q   <= enc_iom_n;
          s1_q      <= enc_s1;
          s0_q      <= enc_s0;
          req_rdy_q <= 1'b0;
          is_read_q <= enc_is_read;
          is_inta_q <= enc_is_inta;
          is_opf_q  <= (bus.cyc_type == CYC_OPF);
          wdata_q   <= bus.wdata;
        end
        BS_T2: begin
          ale_q     <= 1'b0;
          req_rdy_q <= 1'b0;
          if (is_read_q) begin
            ad_oe_q <= 1'b0;
            if (is_inta_q) inta_n_q <= 1'b0;
            else           rd_n_q   <= 1'b0;
          end else begin
            ad_out_q <= wdata_q;
            wr_n_q   <= 1'b0;
          end
        end
        BS_TW: begin
          req_rdy_q <= 1'b0;
        end
        BS_T3: begin
          done_q    <= 1'b1;
          req_rdy_q <= 1'b1;
        end
        default: begin
          req_rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ad_out    = ad_out_q;
  assign bus.ad_oe     = ad_oe_q;
  assign bus.a_hi      = a_hi_q;
  assign bus.ale       = ale_q;
  assign bus.rd_n      = rd_n_q;
  assign bus.wr_n      = wr_n_q;
  assign bus.inta_n    = inta_n_q;
  assign bus.iom_n     = iom_n_q;
  assign bus.s1        = s1_q;
  assign bus.s0        = s0_q;
  assign bus.req_rdy   = req_rdy_q;
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.rdata_vld = rdata_vld_q;
  assign bus.instr     = instr_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: directed scenarios plus randomized
// cycle streams checked against a transaction-level model of the bus cycle.
module tb_bus_cycle_ctrl;

  localparam int MAX_WAIT = 15;
`ifdef BUS_WAIT_STATE_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef struct {
    int          ty;
    logic [15:0] a;
    logic [7:0]  wd;
    int          k;    // READY=0 samples starting at the end of T2
    logic [7:0]  din;  // AD value presented in T3
  } txn_t;

  logic phi1;
  logic reset;

  bus_cycle_ctrl_if bus_if ();

  bus_cycle_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .phi1  (phi1),
    .reset (reset),
    .bus   (bus_if)
  );

  initial phi1 = 1'b0;
  always #5 phi1 = ~phi1;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] m_rdata;
  logic [7:0] m_instr;
  logic       m_iom;
  bit         m_vld;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // {iom_n, s1, s0} for each cycle type.
  function automatic logic [2:0] spec_status(input int ty);
    case (ty)
      0:       return 3'b011;
      1:       return 3'b010;
      2:       return 3'b001;
      3:       return 3'b110;
      4:       return 3'b101;
      5:       return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit spec_reads(input int ty);
    return (ty == 0) || (ty == 1) || (ty == 3) || (ty == 5);
  endfunction

  function automatic txn_t mk(input int ty, input logic [15:0] a, input logic [7:0] wd,
                              input int k, input logic [7:0] din);
    txn_t t;
    t.ty = ty; t.a = a; t.wd = wd; t.k = k; t.din = din;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    int k;
    k = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 18));
    return mk(int'($urandom_range(0, 5)), 16'($urandom), 8'($urandom), k, 8'($urandom));
  endfunction

  task automatic set_req(input txn_t t);
    bus_if.start    = 1'b1;
    bus_if.cyc_type = 3'(t.ty);
    bus_if.addr     = t.a;
    bus_if.wdata    = t.wd;
  endtask

  // One cycle with no real request pending: checks the idle bus.
  task automatic idle_cycle();
    @(negedge phi1);
    bus_if.start    = 1'($urandom_range(0, 1));
    bus_if.cyc_type = 3'($urandom_range(6, 7));
    bus_if.addr     = 16'($urandom);
    bus_if.wdata    = 8'($urandom);
    bus_if.ready    = 1'($urandom_range(0, 1));
    bus_if.ad_in    = 8'($urandom);
    check_eq("idle_ale", bus_if.ale, 0);
    check_eq("idle_ad_oe", bus_if.ad_oe, 0);
    check_eq("idle_strobes", {bus_if.rd_n, bus_if.wr_n, bus_if.inta_n}, 3'b111);
    check_eq("idle_s1s0", {bus_if.s1, bus_if.s0}, 2'b00);
    check_eq("idle_iom_n", bus_if.iom_n, m_iom);
    check_eq("idle_req_rdy", bus_if.req_rdy, 1);
    check_eq("idle_done", bus_if.done, 0);
    check_eq("idle_bus_err", bus_if.bus_err, 0);
    check_eq("idle_rdata_vld", bus_if.rdata_vld, m_vld);
    check_eq("idle_rdata", bus_if.rdata, m_rdata);
    check_eq("idle_instr", bus_if.instr, m_instr);
    m_vld = 0;
  endtask

  // Follows an accepted cycle from T1 to T3; optionally presents the next
  // request during T3 so it starts without a gap.
  task automatic run_body(input txn_t t, input bit has_next, input txn_t n);
    int         w;
    int         len;
    bit         err;
    bit         rd;
    bit         ina;
    bit         last;
    logic [2:0] st;
    w   = WAIT_EN ? ((t.k < MAX_WAIT) ? t.k : MAX_WAIT) : 0;
    err = WAIT_EN && (t.k > MAX_WAIT);
    rd  = spec_reads(t.ty);
    ina = (t.ty == 5);
    st  = spec_status(t.ty);
    len = 3 + w;
    for (int c = 0; c < len; c++) begin
      @(negedge phi1);
      last = (c == len - 1);
      bus_if.ready  = (c == 0 || last) ? 1'($urandom_range(0, 1)) : 1'((c - 1) >= t.k);
      bus_if.ad_in  = last ? t.din : 8'($urandom);
      bus_if.addr   = 16'($urandom);
      bus_if.wdata  = 8'($urandom);
      if (last) begin
        if (has_next) begin
          set_req(n);
        end else begin
          bus_if.start    = 1'($urandom_range(0, 1));
          bus_if.cyc_type = 3'($urandom_range(6, 7));
        end
      end else begin
        bus_if.start    = 1'($urandom_range(0, 1));
        bus_if.cyc_type = 3'($urandom_range(0, 7));
      end

      check_eq("status", {bus_if.iom_n, bus_if.s1, bus_if.s0}, st);
      check_eq("a_hi", bus_if.a_hi, t.a[15:8]);
      check_eq("rdata_vld", bus_if.rdata_vld, (c == 0) ? m_vld : 1'b0);
      check_eq("rdata", bus_if.rdata, m_rdata);
      check_eq("instr", bus_if.instr, m_instr);
      if (c == 0) begin
        check_eq("t1_ale", bus_if.ale, 1);
        check_eq("t1_ad_oe", bus_if.ad_oe, 1);
        check_eq("t1_ad_out", bus_if.ad_out, t.a[7:0]);
        check_eq("t1_strobes", {bus_if.rd_n, bus_if.wr_n, bus_if.inta_n}, 3'b111);
        check_eq("t1_req_rdy", bus_if.req_rdy, 0);
        check_eq("t1_done", bus_if.done, 0);
        m_vld = 0;
      end else begin
        check_eq("ale_low", bus_if.ale, 0);
        check_eq("ad_oe", bus_if.ad_oe, !rd);
        check_eq("rd_n", bus_if.rd_n, !(rd && !ina));
        check_eq("inta_n", bus_if.inta_n, !ina);
        check_eq("wr_n", bus_if.wr_n, rd);
        if (!rd) check_eq("wr_ad_out", bus_if.ad_out, t.wd);
        check_eq("req_rdy", bus_if.req_rdy, last);
        check_eq("done", bus_if.done, last);
        check_eq("bus_err", bus_if.bus_err, last && err);
      end
    end
    if (rd && !err) begin
      m_rdata = t.din;
      m_vld   = 1;
      if (t.ty == 0) m_instr = t.din;
    end
    m_iom = st[2];
  endtask

  task automatic single(input txn_t t);
    txn_t none;
    none = mk(7, 16'h0000, 8'h00, 0, 8'h00);
    set_req(t);
    run_body(t, 1'b0, none);
    idle_cycle();
  endtask

  initial begin
    txn_t t;
    txn_t n;
    txn_t none;
    bit   b2b;

    none = mk(7, 16'h0000, 8'h00, 0, 8'h00);
    reset           = 1'b1;
    bus_if.start    = 1'b0;
    bus_if.cyc_type = 3'd0;
    bus_if.addr     = 16'h0000;
    bus_if.wdata    = 8'h00;
    bus_if.ready    = 1'b1;
    bus_if.ad_in    = 8'h00;
    m_rdata = 8'h00;
    m_instr = 8'h00;
    m_iom   = 1'b0;
    m_vld   = 0;

    // Reset values
    repeat (2) @(negedge phi1);
    check_eq("rst_ale", bus_if.ale, 0);
    check_eq("rst_ad_oe", bus_if.ad_oe, 0);
    check_eq("rst_ad_out", bus_if.ad_out, 8'h00);
    check_eq("rst_a_hi", bus_if.a_hi, 8'h00);
    check_eq("rst_strobes", {bus_if.rd_n, bus_if.wr_n, bus_if.inta_n}, 3'b111);
    check_eq("rst_status", {bus_if.iom_n, bus_if.s1, bus_if.s0}, 3'b000);
    check_eq("rst_req_rdy", bus_if.req_rdy, 1);
    check_eq("rst_done_err", {bus_if.done, bus_if.bus_err, bus_if.rdata_vld}, 3'b000);
    check_eq("rst_rdata", bus_if.rdata, 8'h00);
    check_eq("rst_instr", bus_if.instr, 8'h00);
    reset = 1'b0;
    idle_cycle();

    // Opcode fetch
    single(mk(0, 16'h1234, 8'h00, 0, 8'h3E));
    // Memory write with three wait states
    single(mk(2, 16'h8000, 8'hA5, 3, 8'h5A));
    // I/O read with READY stuck low (times out when wait states are built)
    single(mk(3, 16'h00F0, 8'h00, 40, 8'h77));
    // Back-to-back OPF then MRD
    t = mk(0, 16'h2000, 8'h00, 0, 8'h21);
    n = mk(1, 16'h3001, 8'h00, 1, 8'h9C);
    set_req(t);
    run_body(t, 1'b1, n);
    run_body(n, 1'b0, none);
    idle_cycle();
    // Interrupt acknowledge
    single(mk(5, 16'h0038, 8'h00, 0, 8'hFF));
    // Wait limit exactly reached with READY arriving on the last TW
    single(mk(1, 16'h4455, 8'h00, MAX_WAIT, 8'h66));

    // Asynchronous reset in the middle of a read cycle
    t = mk(1, 16'h4567, 8'h00, 8, 8'h00);
    set_req(t);
    @(negedge phi1);
    bus_if.start = 1'b0;
    bus_if.ready = 1'b0;
    @(negedge phi1);
    bus_if.ready = 1'b0;
    if (WAIT_EN) @(negedge phi1);
    check_eq("pre_rst_rd_n", bus_if.rd_n, 0);
    #1 reset = 1'b1;
    #1;
    check_eq("mid_rst_rd_n", bus_if.rd_n, 1);
    check_eq("mid_rst_ad_oe", bus_if.ad_oe, 0);
    check_eq("mid_rst_req_rdy", bus_if.req_rdy, 1);
    check_eq("mid_rst_done", bus_if.done, 0);
    check_eq("mid_rst_status", {bus_if.iom_n, bus_if.s1, bus_if.s0}, 3'b000);
    m_rdata = 8'h00;
    m_instr = 8'h00;
    m_iom   = 1'b0;
    m_vld   = 0;
    @(negedge phi1);
    reset = 1'b0;
    idle_cycle();
    single(mk(0, 16'h0100, 8'h00, 2, 8'hC3));

    // Randomized stream with random gaps and back-to-back requests
    t = rand_txn();
    set_req(t);
    for (int i = 0; i < 40; i++) begin
      n   = rand_txn();
      b2b = ($urandom_range(0, 2) == 0);
      run_body(t, b2b, n);
      if (!b2b) begin
        repeat ($urandom_range(1, 2)) idle_cycle();
        set_req(n);
      end
      t = n;
    end
    run_body(t, 1'b0, none);
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
